sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
Sits directly downstream of the CPU core. It merges the core's instruction-fetch request port and data-access request port onto one shared req/addr_ok/data_ok memory port that feeds the memory bridge. It tracks in-flight requests in an in-order owner FIFO and routes each returning response to the master that issued it.

Parameters:
OUTSTANDING_DEPTH, 4, max accepted-but-unanswered requests on the shared port; power of two, >=2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
inst_req  in  1  instruction read request; held with inst_addr until inst_addr_ok
inst_addr  in  32  instruction fetch address
inst_addr_ok  out  1  instruction request accepted this cycle
inst_data_ok  out  1  instruction read data valid this cycle (1-cycle pulse)
inst_rdata  out  32  instruction read data
data_req  in  1  data request; fields held stable until data_addr_ok
data_wr  in  1  1 = write, 0 = read
data_wstrb  in  4  byte write strobes
data_addr  in  32  data address
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data response this cycle; read data or write completion
data_rdata  out  32  data read data
out_req  out  1  shared-port request
out_wr  out  1  shared-port write flag
out_wstrb  out  4  shared-port strobes
out_addr  out  32  shared-port address
out_wdata  out  32  shared-port write data
out_addr_ok  in  1  shared port accepted request
out_data_ok  in  1  shared port response; responses return in request order
out_rdata  in  32  shared-port read data

Behaviour:
- Handshake: a request transfers when out_req && out_addr_ok in the same cycle. A response is one cycle with out_data_ok=1. Every request, including writes, gets exactly one response.
- full = (count == OUTSTANDING_DEPTH). While full, out_req=0 and both *_addr_ok=0, even when a pop occurs the same cycle. This keeps data_ok off the combinational path to req.
- Arbitration with no lock held: grant data if data_req, else inst if inst_req.
- Lock: if out_req=1 and out_addr_ok=0, the registers lock_valid=1 and lock_owner=granted master are set. The grant stays with lock_owner until its handshake, so out_* never changes under a pending request.
- Muxing: out_* carry the granted master's fields. For an inst grant, out_wr=0, out_wstrb=0, out_wdata=0.
- Accept: <granted>_addr_ok = out_addr_ok && !full && out_req. The ungranted master's addr_ok is 0.
- Push: on each shared handshake, the owner bit (OWNER_INST/OWNER_DATA) is pushed into the owner FIFO.
- Pop: on out_data_ok with FIFO non-empty, the head is popped. inst_data_ok or data_data_ok is asserted per head, combinationally in the same cycle (zero-cycle response latency).
- Read data: inst_rdata = data_rdata = out_rdata, unregistered.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance. Pointers wrap modulo OUTSTANDING_DEPTH.
- out_data_ok while empty is a protocol violation. It is ignored: no pop, both *_data_ok stay 0, count stays 0.
- Reset: count=0, pointers=0, lock_valid=0. Outputs out_req, *_addr_ok and *_data_ok are 0 during reset. *_rdata follow out_rdata.
- Reset mid-operation: all tracking is dropped. Responses arriving after reset release are discarded by the empty rule.

Optional Feature:
SRAM_ARB_ROUND_ROBIN_EN:
- Defined: on a tie with no lock held, grant the master not granted last. The last_grant register resets to inst, so data wins the first tie.
- Undefined: fixed data priority, and last_grant is not built.

Decomposition:
- Shared package: OWNER_INST=1'b0, OWNER_DATA=1'b1, ADDR_W=32, DATA_W=32, STRB_W=4.
- One sub-module, owner_fifo: synchronous 1-bit-wide FIFO, depth OUTSTANDING_DEPTH, push/pop/full/empty/head; the same synchronous active-high reset.

Test Plan:
- Single inst read 0x1C000000, out_addr_ok=1, out_data_ok 2 cycles later with rdata 0x02C00000 -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata=0x02C00000; data_data_ok=0.
- inst_req and data_req both high (data write 0x80000000, wstrb 0xF, wdata 0x12345678) -> data granted first, then inst next cycle. Responses arriving D then I pulse data_data_ok then inst_data_ok. With SRAM_ARB_ROUND_ROBIN_EN, a second tie grants inst.
- Data read held with out_addr_ok=0 for 3 cycles while inst_req rises -> out_addr/out_wr stay at the data request; inst is not granted until the data handshake.
- 4 reads accepted, no responses -> 5th request sees out_req=0 and addr_ok=0. One out_data_ok in the same cycle still blocks; accepted the next cycle.
- out_data_ok pulse with nothing outstanding -> no *_data_ok, count stays 0.
- Reset asserted with 2 outstanding -> out_req=0, count=0; a response after release produces no *_data_ok.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants and request bundle for the SRAM request arbiter.
// Owner encoding identifies which master issued an in-flight request.
package sram_req_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef struct packed {
    logic              wr;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;
endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// In-order 1-bit owner FIFO tracking requests awaiting a response.
// Synchronous active-high reset clears pointers and occupancy.
module owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      count;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];
endmodule

// File: rtl/sram_req_arbiter.sv
// Merges inst and data request ports onto one shared SRAM-like port.
// Optional SRAM_ARB_ROUND_ROBIN_EN: alternate grants on ties.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        out_req,
  output logic        out_wr,
  output logic [3:0]  out_wstrb,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  input  logic        out_addr_ok,
  input  logic        out_data_ok,
  input  logic [31:0] out_rdata
);
  logic  full;
  logic  empty;
  logic  head;
  logic  grant;
  logic  hs;
  logic  pop;
  logic  lock_valid;
  logic  lock_owner;
  mreq_t inst_f;
  mreq_t data_f;
  mreq_t sel;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_grant;
`endif

  always_comb begin
    grant = data_req ? OWNER_DATA : OWNER_INST;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    if (inst_req && data_req)
      grant = (last_grant == OWNER_INST) ? OWNER_DATA : OWNER_INST;
`endif
    if (lock_valid) grant = lock_owner;
  end

  always_comb begin
    inst_f = '{wr: 1'b0, wstrb: '0, addr: inst_addr, wdata: '0};
    data_f = '{wr: data_wr, wstrb: data_wstrb,
               addr: data_addr, wdata: data_wdata};
    sel    = (grant == OWNER_DATA) ? data_f : inst_f;
  end

  // Gating on full keeps out_data_ok off the path to out_req.
  assign out_req = !reset && !full &&
                   ((grant == OWNER_DATA) ? data_req : inst_req);
  assign out_wr    = sel.wr;
  assign out_wstrb = sel.wstrb;
  assign out_addr  = sel.addr;
  assign out_wdata = sel.wdata;

  assign hs           = out_req && out_addr_ok;
  assign inst_addr_ok = hs && (grant == OWNER_INST);
  assign data_addr_ok = hs && (grant == OWNER_DATA);

  assign pop          = out_data_ok && !empty && !reset;
  assign inst_data_ok = pop && (head == OWNER_INST);
  assign data_data_ok = pop && (head == OWNER_DATA);
  assign inst_rdata   = out_rdata;
  assign data_rdata   = out_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_owner <= OWNER_INST;
    end else if (out_req && !out_addr_ok) begin
      lock_valid <= 1'b1;
      lock_owner <= grant;
    end else if (hs) begin
      lock_valid <= 1'b0;
    end
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset)   last_grant <= OWNER_INST;
    else if (hs) last_grant <= grant;
  end
`endif

  owner_fifo #(.DEPTH(OUTSTANDING_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (hs),
    .din   (grant),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: queue-based model plus
// directed scenarios with literal expectations.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  localparam int DEPTH = 4;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        out_req;
  logic        out_wr;
  logic [3:0]  out_wstrb;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic        out_addr_ok;
  logic        out_data_ok;
  logic [31:0] out_rdata;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTANDING_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .out_req      (out_req),
    .out_wr       (out_wr),
    .out_wstrb    (out_wstrb),
    .out_addr     (out_addr),
    .out_wdata    (out_wdata),
    .out_addr_ok  (out_addr_ok),
    .out_data_ok  (out_data_ok),
    .out_rdata    (out_rdata)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Model state: in-flight owners in issue order, plus lock and last grant.
  logic oq[$];
  logic lk_v   = 1'b0;
  logic lk_o   = OWNER_INST;
  logic last_g = OWNER_INST;

  initial begin
    logic g, er, hs, pp, fl;
    forever begin
      @(negedge clk);
      fl = (oq.size() == DEPTH);
      if (lk_v) g = lk_o;
      else if (data_req && inst_req)
        g = (RR && last_g == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
      else g = data_req ? OWNER_DATA : OWNER_INST;
      er = !reset && !fl && (g == OWNER_DATA ? data_req : inst_req);
      hs = er && out_addr_ok;
      pp = !reset && out_data_ok && (oq.size() > 0);
      chk1("out_req", out_req, er);
      if (er) begin
        chk32("out_addr", out_addr, g ? data_addr : inst_addr);
        chk1("out_wr", out_wr, g ? data_wr : 1'b0);
        chk32("out_wstrb", {28'd0, out_wstrb},
              {28'd0, g ? data_wstrb : 4'd0});
        chk32("out_wdata", out_wdata, g ? data_wdata : 32'd0);
      end
      chk1("inst_addr_ok", inst_addr_ok, hs && g == OWNER_INST);
      chk1("data_addr_ok", data_addr_ok, hs && g == OWNER_DATA);
      chk1("inst_data_ok", inst_data_ok, pp && oq[0] == OWNER_INST);
      chk1("data_data_ok", data_data_ok, pp && oq[0] == OWNER_DATA);
      chk32("inst_rdata", inst_rdata, out_rdata);
      chk32("data_rdata", data_rdata, out_rdata);
      if (reset) begin
        oq.delete();
        lk_v   = 1'b0;
        last_g = OWNER_INST;
      end else begin
        if (pp) void'(oq.pop_front());
        if (hs) oq.push_back(g);
        if (er && !out_addr_ok) begin
          lk_v = 1'b1;
          lk_o = g;
        end else if (hs) lk_v = 1'b0;
        if (hs) last_g = g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req    = 1'b0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = 4'h0;
    out_addr_ok = 1'b0;
    out_data_ok = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      out_data_ok = 1'b1;
      out_rdata   = 32'hA000_0000 + i;
      step();
    end
    out_data_ok = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    inst_addr  = 32'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    out_rdata  = 32'h0;
    idle();
    inst_req = 1'b1;
    step();
    samp();
    chk1("rst_out_req", out_req, 1'b0);
    chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    step();
    reset = 1'b0;
    idle();
    step();

    // Single instruction read
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0000;
    out_addr_ok = 1'b1;
    samp();
    chk1("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    chk32("t1_out_addr", out_addr, 32'h1C00_0000);
    step();
    idle();
    step();
    out_data_ok = 1'b1;
    out_rdata   = 32'h02C0_0000;
    samp();
    chk1("t1_inst_data_ok", inst_data_ok, 1'b1);
    chk32("t1_inst_rdata", inst_rdata, 32'h02C0_0000);
    chk1("t1_data_data_ok", data_data_ok, 1'b0);
    step();
    idle();
    step();

    // Tie: data write first, inst next; responses D then I
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0004;
    data_req    = 1'b1;
    data_wr     = 1'b1;
    data_wstrb  = 4'hF;
    data_addr   = 32'h8000_0000;
    data_wdata  = 32'h1234_5678;
    out_addr_ok = 1'b1;
    samp();
    chk1("t2_data_addr_ok", data_addr_ok, 1'b1);
    chk1("t2_inst_blocked", inst_addr_ok, 1'b0);
    chk32("t2_out_wdata", out_wdata, 32'h1234_5678);
    step();
    data_req = 1'b0;
    samp();
    chk1("t2_inst_addr_ok", inst_addr_ok, 1'b1);
    chk1("t2_inst_out_wr", out_wr, 1'b0);
    step();
    idle();
    out_data_ok = 1'b1;
    out_rdata   = 32'h0000_0001;
    samp();
    chk1("t2_resp_d", data_data_ok, 1'b1);
    step();
    out_data_ok = 1'b1;
    out_rdata   = 32'h0000_0002;
    samp();
    chk1("t2_resp_i", inst_data_ok, 1'b1);
    step();
    idle();
    step();

    // Back-to-back ties: round robin hands the second to inst
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0020;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_addr   = 32'h8000_0020;
    out_addr_ok = 1'b1;
    samp();
    chk1("t2b_first_data", data_addr_ok, 1'b1);
    step();
    data_addr = 32'h8000_0024;
    samp();
    chk1("t2b_second_inst", inst_addr_ok, RR);
    chk1("t2b_second_data", data_addr_ok, !RR);
    step();
    if (RR) inst_req = 1'b0;
    else    data_req = 1'b0;
    samp();
    chk1("t2b_third_inst", inst_addr_ok, !RR);
    step();
    idle();
    drain(3);
    step();

    // Locked data read while inst rises
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h8000_0010;
    step();
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0010;
    for (int i = 0; i < 2; i++) begin
      samp();
      chk32("t3_lock_addr", out_addr, 32'h8000_0010);
      chk1("t3_lock_inst", inst_addr_ok, 1'b0);
      step();
    end
    out_addr_ok = 1'b1;
    samp();
    chk1("t3_data_hs", data_addr_ok, 1'b1);
    step();
    data_req = 1'b0;
    samp();
    chk1("t3_inst_hs", inst_addr_ok, 1'b1);
    step();
    idle();
    drain(2);
    step();

    // Fill to depth, then pop in the same cycle still blocks
    data_req    = 1'b1;
    out_addr_ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      data_addr = 32'h8000_0100 + 32'(i * 4);
      step();
    end
    data_addr = 32'h8000_0200;
    samp();
    chk1("t4_full_req", out_req, 1'b0);
    chk1("t4_full_ok", data_addr_ok, 1'b0);
    step();
    out_data_ok = 1'b1;
    out_rdata   = 32'h0000_00AA;
    samp();
    chk1("t4_pop_block", data_addr_ok, 1'b0);
    chk1("t4_pop_resp", data_data_ok, 1'b1);
    step();
    out_data_ok = 1'b0;
    samp();
    chk1("t4_after_pop", data_addr_ok, 1'b1);
    step();
    idle();
    drain(DEPTH);
    step();

    // Stray response while empty
    out_data_ok = 1'b1;
    samp();
    chk1("t5_stray_i", inst_data_ok, 1'b0);
    chk1("t5_stray_d", data_data_ok, 1'b0);
    step();
    out_data_ok = 1'b0;
    inst_req    = 1'b1;
    inst_addr   = 32'h1C00_0040;
    out_addr_ok = 1'b1;
    step();
    idle();
    out_data_ok = 1'b1;
    samp();
    chk1("t5_count_zero", inst_data_ok, 1'b1);
    step();
    idle();
    step();

    // Reset with two outstanding
    inst_req    = 1'b1;
    out_addr_ok = 1'b1;
    inst_addr   = 32'h1C00_0080;
    step();
    inst_addr   = 32'h1C00_0084;
    step();
    reset = 1'b1;
    samp();
    chk1("t6_rst_req", out_req, 1'b0);
    chk1("t6_rst_ok", inst_addr_ok, 1'b0);
    step();
    reset = 1'b0;
    idle();
    out_data_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      samp();
      chk1("t6_drop_i", inst_data_ok, 1'b0);
      chk1("t6_drop_d", data_data_ok, 1'b0);
      step();
    end
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
